// File: rtl/node_seq.sv
// Sequenced multiply-accumulate neuron engine: streams weights and bias for NN neurons
// from an external synchronous memory and emits one fixed-point pre-activation per neuron.
module node_seq #(
    parameter int SX = 2,
    parameter int NN = 4,
    parameter int N  = 32,
    parameter int F  = 24,
    localparam int AW   = (NN * (SX + 1) > 1) ? $clog2(NN * (SX + 1)) : 1,
    localparam int KW   = (NN > 1) ? $clog2(NN) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N*SX-1:0] nx,
    output logic            w_en,
    output logic [AW-1:0]   w_addr,
    input  logic [N-1:0]    w_data,
    output logic [N-1:0]    z,
    output logic [KW-1:0]   z_idx,
    output logic            z_valid,
    input  logic            z_ready,
    output logic            busy,
    output logic            done
);

    localparam int JW   = (SX > 0) ? $clog2(SX + 1) : 1;
    localparam int ACCW = 2 * N + $clog2(SX + 1);
    localparam logic [JW-1:0] JLAST = JW'(SX);
    localparam logic [KW-1:0] KLAST = KW'(NN - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

    state_t            state;
    logic [N-1:0]      xl [SX];
    logic [KW-1:0]     k;
    logic [JW-1:0]     j;
    logic              rd_v;
    logic [JW-1:0]     rd_j;
    logic              fin;
    logic [ACCW-1:0]   acc;

    logic [N-1:0]      x_sel;
    logic [2*N-1:0]    prod;
    logic [ACCW-1:0]   term;

    // Low 2N bits of the product of sign-extended operands equal the exact signed product.
    always_comb begin
        x_sel = '0;
        for (int unsigned i = 0; i < SX; i++) begin
            if (rd_j == JW'(i)) x_sel = xl[i];
        end
        prod = {{N{x_sel[N-1]}}, x_sel} * {{N{w_data[N-1]}}, w_data};
        if (rd_j == JLAST)
            term = {{(ACCW-N){w_data[N-1]}}, w_data} << F;
        else
            term = {{(ACCW-2*N){prod[2*N-1]}}, prod};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            for (int unsigned i = 0; i < SX; i++) xl[i] <= '0;
            k       <= '0;
            j       <= '0;
            rd_v    <= 1'b0;
            rd_j    <= '0;
            fin     <= 1'b0;
            acc     <= '0;
            w_en    <= 1'b0;
            w_addr  <= '0;
            z       <= '0;
            z_idx   <= '0;
            z_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            fin  <= 1'b0;
            // Memory samples the address on this edge; its data is captured one edge later.
            rd_v <= w_en;
            rd_j <= j;
            if (rd_v) begin
                acc <= ((rd_j == '0) ? '0 : acc) + term;
                if (rd_j == JLAST) fin <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < SX; i++) xl[i] <= nx[i*N +: N];
                        k      <= '0;
                        j      <= '0;
                        busy   <= 1'b1;
                        w_en   <= 1'b1;
                        w_addr <= '0;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (j == JLAST) begin
                        w_en  <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        j      <= j + 1'b1;
                        w_addr <= w_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (fin) begin
                        z       <= acc[N+F-1:F];
                        z_idx   <= k;
                        z_valid <= 1'b1;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    if (z_ready) begin
                        z_valid <= 1'b0;
                        if (k == KLAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            k      <= k + 1'b1;
                            j      <= '0;
                            w_en   <= 1'b1;
                            w_addr <= w_addr + 1'b1;
                            state  <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_node_seq.sv
// Randomised and directed checks of node_seq against an arithmetic reference model
// with a registered weight memory in the bench.
module tb_node_seq;

    localparam int SX = 2;
    localparam int NN = 2;
    localparam int N  = 32;
    localparam int F  = 24;
    localparam int AW = 3;
    localparam int KW = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            z_ready = 1'b0;
    logic [N*SX-1:0] nx = '0;
    logic            w_en;
    logic [AW-1:0]   w_addr;
    logic [N-1:0]    w_data = '0;
    logic [N-1:0]    z;
    logic [KW-1:0]   z_idx;
    logic            z_valid;
    logic            busy;
    logic            done;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [NN*(SX+1)];
    logic [31:0] xv  [SX];
    logic [31:0] res [8];

    node_seq #(.SX(SX), .NN(NN), .N(N), .F(F)) dut (
        .clk(clk), .rst(rst), .start(start), .nx(nx),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .z(z), .z_idx(z_idx), .z_valid(z_valid), .z_ready(z_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (w_en) w_data <= mem[w_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // floor(sum(x*w) + b) in Q(N-F).F, wrapped to N bits
    function automatic logic [31:0] model_z(input int kk);
        logic signed [127:0] s, a, b;
        s = '0;
        for (int jj = 0; jj < SX; jj++) begin
            a = $signed(xv[jj]);
            b = $signed(mem[kk*(SX+1)+jj]);
            s = s + a * b;
        end
        a = $signed(mem[kk*(SX+1)+SX]);
        s = s + (a <<< F);
        return s[N+F-1:F];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input logic [31:0] a, input logic [31:0] b);
        xv[0] = a;
        xv[1] = b;
        nx = {b, a};
    endtask

    task automatic collect(input bit rand_ready, input bit spam, input int budget);
        int nres = 0;
        int ndone = 0;
        int post = 0;
        for (int c = 0; c < budget; c++) begin
            z_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (spam) nx = {$urandom, $urandom};
            if (z_valid && z_ready) begin
                if (nres < NN) begin
                    check("z", z, model_z(nres));
                    check("z_idx", z_idx, nres);
                end
                if (nres < 8) res[nres] = z;
                nres++;
            end
            tick();
            if (done) begin
                ndone++;
                start = 1'b0;
            end
            if (ndone > 0) post++;
            if (post > 5) break;
        end
        check("n_results", nres, NN);
        check("n_done", ndone, 1);
        check("busy_end", busy, 0);
        start = 1'b0;
        z_ready = 1'b0;
        nx = {xv[1], xv[0]};
    endtask

    task automatic run(input bit rand_ready, input bit spam);
        start = 1'b1;
        tick();
        if (!spam) start = 1'b0;
        collect(rand_ready, spam, 200);
    endtask

    initial begin
        int cnt;
        logic [31:0] z0;
        logic [KW-1:0] zi0;

        tick();
        tick();
        check("rst_w_en", w_en, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_z", z, 0);
        check("rst_z_idx", z_idx, 0);
        check("rst_z_valid", z_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        tick();

        // Basic run with cycle-exact latency
        set_x(32'h0200_0000, 32'hFF00_0000);
        mem[0] = 32'h0100_0000; mem[1] = 32'h0080_0000; mem[2] = 32'h0040_0000;
        mem[3] = 32'hFF80_0000; mem[4] = 32'hFF80_0000; mem[5] = 32'h0000_0000;
        z_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_E_w_en", w_en, 1);
        check("lat_E_addr", w_addr, 0);
        check("lat_E_busy", busy, 1);
        tick();
        check("lat_E1_addr", w_addr, 1);
        tick();
        check("lat_E2_addr", w_addr, 2);
        check("lat_E2_w_en", w_en, 1);
        tick();
        check("lat_E3_w_en", w_en, 0);
        tick();
        check("lat_E4_valid", z_valid, 0);
        tick();
        check("lat_E5_valid", z_valid, 1);
        check("basic_z0", z, 32'h01C0_0000);
        check("basic_idx0", z_idx, 0);
        tick();
        check("hs_valid_drop", z_valid, 0);
        check("hs_w_en", w_en, 1);
        check("hs_addr", w_addr, 3);
        for (int i = 0; i < 4; i++) tick();
        check("n1_E10_valid", z_valid, 0);
        tick();
        check("n1_valid", z_valid, 1);
        check("basic_z1", z, 32'hFF80_0000);
        check("basic_idx1", z_idx, 1);
        tick();
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_valid", z_valid, 0);
        tick();
        check("done_pulse", done, 0);

        // Backpressure holds the first result
        z_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while (!z_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("bp_valid", z_valid, 1);
        check("bp_z", z, model_z(0));
        z0 = z;
        zi0 = z_idx;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_z", z, z0);
            check("bp_hold_idx", z_idx, zi0);
            check("bp_hold_valid", z_valid, 1);
            check("bp_w_en", w_en, 0);
        end
        collect(0, 0, 200);

        // Overflow wraps
        set_x(32'h6400_0000, 32'h0000_0000);
        mem[0] = 32'h6400_0000; mem[1] = $urandom; mem[2] = 32'h0000_0000;
        run(0, 0);
        check("ovf_z", res[0], 32'h1000_0000);

        // Start held high throughout the run, nx toggling
        set_x($urandom, $urandom);
        for (int i = 0; i < NN*(SX+1); i++) mem[i] = $urandom;
        run(1, 1);

        // Reset mid-FETCH
        z_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        check("mr_w_en", w_en, 0);
        check("mr_w_addr", w_addr, 0);
        check("mr_z", z, 0);
        check("mr_z_idx", z_idx, 0);
        check("mr_z_valid", z_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        tick();
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (w_en || z_valid || busy || done) cnt++;
        end
        check("mr_quiet", cnt, 0);
        run(0, 0);

        // Random runs
        for (int r = 0; r < 25; r++) begin
            set_x($urandom, $urandom);
            for (int i = 0; i < NN*(SX+1); i++) mem[i] = $urandom;
            run(1, 0);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
